uart_serializer: RTL and testbench



---
 rtl/uart_serializer_if.sv | 19 +
 rtl/uart_serializer.sv | 182 ++++++++++++++++++
 tb/tb_uart_serializer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_serializer_if.sv
// uart_serializer_if: byte-wide AXI-Stream link into the UART serializer.
// Signals: tdata[7:0], tvalid (master -> slave), tready (slave -> master).
interface uart_serializer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/uart_serializer.sv
// uart_serializer: AXI-Stream byte sink driving an async serial TX line.
// Frame: start(0), 8 data LSB first, optional parity, STOP_BITS of 1.
// Ports: clk, reset (sync, active high), s_axis (slave: tdata/tvalid/tready),
//   txd (registered serial out, idle high), busy (frame on the line).
// Optional macro UART_SERIALIZER_PARITY_EN adds a parity bit after DATA
//   (even when PARITY_ODD=0, odd when PARITY_ODD=1).
module uart_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic         clk,
  input  logic         reset,
  uart_serializer_if.slave s_axis,
  output logic         txd,
  output logic         busy
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_serializer: illegal parameter value");
  end

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
`ifdef UART_SERIALIZER_PARITY_EN
  logic          par_q, par_d;
`endif

  logic bit_end;
  logic last_stop;
  logic ready;
  logic accept;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign last_stop = (state_q == S_STOP) && (bit_q == STOP_LAST) && bit_end;

  // Reset gates tready so no byte is taken while the block is held.
  assign ready  = !reset && ((state_q == S_IDLE) || last_stop);
  assign accept = s_axis.tvalid && ready;

  assign s_axis.tready = ready;
  assign txd           = txd_q;
  assign busy          = busy_q;

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
`ifdef UART_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = sh_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_SERIALIZER_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            txd_d = sh_q[1];
          end
        end
      end
`ifdef UART_SERIALIZER_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A new byte overrides the idle/stop outcome so frames abut.
    if (accept) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      sh_d    = s_axis.tdata;
      txd_d   = 1'b0;
      busy_d  = 1'b1;
`ifdef UART_SERIALIZER_PARITY_EN
      par_d   = (^s_axis.tdata) ^ (PARITY_ODD != 0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_serializer.sv
// tb_uart_serializer: two serializers (1 and 2 stop bits) fed one stream,
// each checked every cycle against a frame-position model.
module tb_uart_serializer;
  localparam int C = 4;
`ifdef UART_SERIALIZER_PARITY_EN
  localparam int P = 1;
  localparam int LIT_FL0 = 44;
  localparam int LIT_FL1 = 48;
  localparam int STOP1_START = 41;
  localparam logic PAR0_07 = 1'b1;
  localparam logic PAR1_07 = 1'b0;
`else
  localparam int P = 0;
  localparam int LIT_FL0 = 40;
  localparam int LIT_FL1 = 44;
  localparam int STOP1_START = 37;
  localparam logic PAR0_07 = 1'b1;
  localparam logic PAR1_07 = 1'b1;
`endif
  localparam int FL0 = (9 + P + 1) * C;
  localparam int FL1 = (9 + P + 2) * C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic tvalid = 1'b0;
  logic txd0, busy0, txd1, busy1;

  uart_serializer_if a0 ();
  uart_serializer_if a1 ();
  assign a0.tdata  = tdata;
  assign a0.tvalid = tvalid;
  assign a1.tdata  = tdata;
  assign a1.tvalid = tvalid;

  uart_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .s_axis(a0), .txd(txd0), .busy(busy0));
  uart_serializer #(.CLKS_PER_BIT(C), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
    .clk(clk), .reset(reset), .s_axis(a1), .txd(txd1), .busy(busy1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rem[2] = '{0, 0};
  logic [7:0] mbyte[2] = '{8'h00, 8'h00};
  int macc[2] = '{0, 0};
  int dacc[2] = '{0, 0};
  longint dcyc[2] = '{0, 0};
  longint cyc = 0;
  bit started = 1'b0;

  function automatic int flen(input int i);
    return (i == 0) ? FL0 : FL1;
  endfunction

  function automatic logic exp_ready(input int i);
    return !reset && (rem[i] <= 1);
  endfunction

  // Expected line level from position within the current frame.
  function automatic logic exp_txd(input int i);
    int pos;
    int b;
    logic pb;
    if (rem[i] == 0) return 1'b1;
    pos = flen(i) - rem[i];
    b = pos / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return mbyte[i][b-1];
    if (P == 1 && b == 9) begin
      pb = ^mbyte[i];
      if (i == 1) pb = ~pb;
      return pb;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    logic r;
    cyc++;
    started = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r = exp_ready(i);
      if (reset) begin
        rem[i] = 0;
      end else begin
        if (rem[i] > 0) rem[i]--;
        if (tvalid && r) begin
          rem[i] = flen(i);
          mbyte[i] = tdata;
          macc[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("txd0", 32'(txd0), 32'(exp_txd(0)));
      chk("busy0", 32'(busy0), 32'(rem[0] > 0));
      chk("tready0", 32'(a0.tready), 32'(exp_ready(0)));
      chk("txd1", 32'(txd1), 32'(exp_txd(1)));
      chk("busy1", 32'(busy1), 32'(rem[1] > 0));
      chk("tready1", 32'(a1.tready), 32'(exp_ready(1)));
      if (!reset && tvalid && a0.tready) begin
        dacc[0]++;
        dcyc[0] = cyc;
      end
      if (!reset && tvalid && a1.tready) begin
        dacc[1]++;
        dcyc[1] = cyc;
      end
    end
  end

  task automatic run_frame(input logic [7:0] b, output logic [8:0] bits,
                           output logic pb0, output logic pb1,
                           output int bcnt);
    bits = '0;
    pb0 = 1'b0;
    pb1 = 1'b0;
    bcnt = 0;
    tdata = b;
    tvalid = 1'b1;
    @(posedge clk);
    #1 tvalid = 1'b0;
    for (int k = 1; k <= FL1 + 4; k++) begin
      @(negedge clk);
      if (busy0) bcnt++;
      if (k <= 8 * C + 1 && (k - 1) % C == 0) bits[(k-1)/C] = txd0;
      if (k == 9 * C + 1) begin
        pb0 = txd0;
        pb1 = txd1;
      end
    end
  endtask

  initial begin
    logic [8:0] bits;
    logic pb0, pb1;
    int bcnt, gap, base0, ones, k;
    longint first;
    int a1c;

    @(posedge clk);
    @(negedge clk);
    chk("rst_txd", 32'(txd0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_tready", 32'(a0.tready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 32'(a0.tready), 32'd1);

    repeat (100) @(posedge clk);
    #1;
    chk("idle_txd", 32'(txd0), 32'd1);
    chk("idle_busy", 32'(busy0), 32'd0);

    run_frame(8'h55, bits, pb0, pb1, bcnt);
    chk("f55_bits", 32'(bits), 32'h0AA);
    chk("f55_busy_len", 32'(bcnt), 32'(LIT_FL0));

    run_frame(8'h07, bits, pb0, pb1, bcnt);
    chk("f07_bits", 32'(bits), 32'h00E);
    chk("f07_par_even", 32'(pb0), 32'(PAR0_07));
    chk("f07_par_odd", 32'(pb1), 32'(PAR1_07));
    chk("f07_busy_len", 32'(bcnt), 32'(LIT_FL0));

    base0 = dacc[0];
    tdata = 8'h00;
    tvalid = 1'b1;
    @(posedge clk);
    #1 tdata = 8'hFF;
    gap = 0;
    for (k = 1; k <= 2 * FL0; k++) begin
      @(negedge clk);
      if (!busy0) gap++;
      if (k == FL0) chk("b2b_stop", 32'(txd0), 32'd1);
      if (k == FL0 + 1) chk("b2b_start2", 32'(txd0), 32'd0);
      if (k == FL0 + 5) chk("b2b_ff_d0", 32'(txd0), 32'd1);
      if (k == FL1 + 1) tvalid = 1'b0;
    end
    chk("b2b_gap", 32'(gap), 32'd0);
    chk("b2b_accepts", 32'(dacc[0] - base0), 32'd2);
    repeat (FL1 + 4) @(posedge clk);
    #1;

    tdata = 8'hA3;
    tvalid = 1'b1;
    @(posedge clk);
    #1 tdata = 8'h5A;
    first = dcyc[1];
    a1c = dacc[1];
    ones = 0;
    k = 0;
    while (dacc[1] == a1c && k < 200) begin
      @(negedge clk);
      #1;
      k++;
      if (k >= STOP1_START && k < STOP1_START + 8 && txd1) ones++;
    end
    if (dacc[1] == a1c) begin
      checks++;
      errors++;
      $display("FAIL stop2_timeout: no second accept within 200 cycles");
    end
    @(posedge clk);
    #1 tvalid = 1'b0;
    chk("stop2_high", 32'(ones), 32'd8);
    chk("stop2_interval", 32'(dcyc[1] - first), 32'(LIT_FL1));
    repeat (2 * FL1 + 4) @(posedge clk);
    #1;

    tdata = 8'hC3;
    tvalid = 1'b1;
    @(posedge clk);
    #1 tvalid = 1'b0;
    repeat (17) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_txd", 32'(txd0), 32'd1);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_tready", 32'(a0.tready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_rel_tready", 32'(a0.tready), 32'd1);
    run_frame(8'h12, bits, pb0, pb1, bcnt);
    chk("f12_bits", 32'(bits), 32'h024);
    chk("f12_busy_len", 32'(bcnt), 32'(LIT_FL0));

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      tvalid = ($urandom_range(0, 9) < 7);
      tdata = 8'($urandom);
      reset = ($urandom_range(0, 699) == 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tvalid = 1'b0;
    repeat (FL1 + 4) @(posedge clk);
    #1;
    chk("acc_count0", 32'(dacc[0]), 32'(macc[0]));
    chk("acc_count1", 32'(dacc[1]), 32'(macc[1]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
